// File: rtl/mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module   : mix_columns_seq
// Brief    : Iterative AES forward MixColumns, COLS_PER_CYCLE columns/clock,
//            valid/ready in and out, result held until taken downstream.
// Revision : 1.0 - initial release
// ============================================================================
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam int         c_ngroups  = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] c_last_grp = 2'(c_ngroups - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] x0, x1, x2, x3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        x0 = xtime(a0);
        x1 = xtime(a1);
        x2 = xtime(a2);
        x3 = xtime(a3);
        // 3a = xtime(a) ^ a
        return {x0 ^ (x1 ^ a1) ^ a2 ^ a3,
                a0 ^ x1 ^ (x2 ^ a2) ^ a3,
                a0 ^ a1 ^ x2 ^ (x3 ^ a3),
                (x0 ^ a0) ^ a1 ^ a2 ^ x3};
    endfunction

    logic [1:0]   r_state;
    logic [1:0]   r_grp;
    logic [127:0] r_src;
    logic [127:0] r_res;

    logic [31:0]  w_src_col [4];
    logic [1:0]   w_col_idx [COLS_PER_CYCLE];
    logic [31:0]  w_mix     [COLS_PER_CYCLE];

    generate
        for (genvar c = 0; c < 4; c++) begin : g_unpack
            assign w_src_col[c] = r_src[(3 - c) * 32 +: 32];
        end
        // Lane j of group g works on column g*COLS_PER_CYCLE + j.
        for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_lane
            assign w_col_idx[j] = 2'((int'(r_grp) * COLS_PER_CYCLE + j) % 4);
            assign w_mix[j]     = mix_col(w_src_col[w_col_idx[j]]);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_grp   <= 2'd0;
            r_src   <= 128'd0;
            r_res   <= 128'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_src   <= in_data;
                        r_grp   <= 2'd0;
                        r_state <= c_st_busy;
                    end
                end
                c_st_busy: begin
                    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
                        r_res[(3 - int'(w_col_idx[j])) * 32 +: 32] <= w_mix[j];
                    end
                    r_grp <= r_grp + 2'd1;
                    if (r_grp == c_last_grp) begin
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    if (out_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Handshake flags depend on the state register only.
    assign in_ready  = (r_state == c_st_idle);
    assign out_valid = (r_state == c_st_done);
    assign busy      = (r_state == c_st_busy) || (r_state == c_st_done);
    assign out_data  = r_res;

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mix_columns_seq
// Brief    : Directed and randomised self-checking bench for mix_columns_seq,
//            one instance per legal COLS_PER_CYCLE (1, 2, 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mix_columns_seq;

    localparam logic [127:0] c_fips_in  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] c_fips_out = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] c_col1_in  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] c_col1_out = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] c_col2_in  = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
    localparam logic [127:0] c_col2_out = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;
    localparam int           c_nrand    = 1000;

    logic         clk;
    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_data   [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_data  [3];
    logic         busy      [3];

    int n_checks;
    int n_fail;
    logic [127:0] exp_q [$];

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid[g]),
                .in_ready  (in_ready[g]),
                .in_data   (in_data[g]),
                .out_valid (out_valid[g]),
                .out_ready (out_ready[g]),
                .out_data  (out_data[g]),
                .busy      (busy[g])
            );
        end
    endgenerate

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: circulant matrix {2,3,1,1} built on a generic GF(2^8) multiply.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s);
        logic [7:0] coef [4];
        logic [7:0] acc;
        logic [127:0] r;
        coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gf_mul(coef[(j - i + 4) % 4], s[127 - 8 * (4 * c + j) -: 8]);
                end
                r[127 - 8 * (4 * c + i) -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 4 : (k == 1) ? 2 : 1;
    endfunction

    // Drives one state into an idle engine with out_ready high; returns the
    // captured result, the accept-to-out_valid edge count and post-handshake flags.
    task automatic run_one(input int k, input logic [127:0] d,
                           output logic [127:0] r, output int lat, output bit ok_after);
        bit seen;
        out_ready[k] = 1'b1;
        in_data[k]   = d;
        in_valid[k]  = 1'b1;
        @(posedge clk); #1;
        in_valid[k]  = 1'b0;
        in_data[k]   = ~d;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid[k] === 1'b1) seen = 1'b1;
        end
        r = out_data[k];
        @(posedge clk); #1;
        ok_after = (out_valid[k] === 1'b0) && (in_ready[k] === 1'b1);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (in_ready[k] !== 1'b1) begin
                n_fail++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", k, in_ready[k]);
            end
            n_checks++;
            if (out_valid[k] !== 1'b0) begin
                n_fail++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", k, out_valid[k]);
            end
            n_checks++;
            if (busy[k] !== 1'b0) begin
                n_fail++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, busy[k]);
            end
            n_checks++;
            if (out_data[k] !== 128'd0) begin
                n_fail++; $display("FAIL reset_out_data[%0d]: got %h expected 0", k, out_data[k]);
            end
        end
    endtask

    task automatic test_fips(input int k);
        logic [127:0] r;
        int lat;
        bit ok_after;
        run_one(k, c_fips_in, r, lat, ok_after);
        n_checks++;
        if (r !== c_fips_out) begin
            n_fail++; $display("FAIL fips_data[%0d]: got %h expected %h", k, r, c_fips_out);
        end
        n_checks++;
        if (lat !== lat_of(k)) begin
            n_fail++; $display("FAIL fips_latency[%0d]: got %0d expected %0d", k, lat, lat_of(k));
        end
        n_checks++;
        if (!ok_after) begin
            n_fail++; $display("FAIL fips_release[%0d]: got out_valid=%b in_ready=%b expected 0/1",
                               k, out_valid[k], in_ready[k]);
        end
    endtask

    task automatic test_columns(input int k);
        logic [127:0] r;
        int lat;
        bit ok_after;
        run_one(k, c_col1_in, r, lat, ok_after);
        n_checks++;
        if (r !== c_col1_out) begin
            n_fail++; $display("FAIL col1_data[%0d]: got %h expected %h", k, r, c_col1_out);
        end
        n_checks++;
        if (lat !== lat_of(k)) begin
            n_fail++; $display("FAIL col1_latency[%0d]: got %0d expected %0d", k, lat, lat_of(k));
        end
        run_one(k, c_col2_in, r, lat, ok_after);
        n_checks++;
        if (r !== c_col2_out) begin
            n_fail++; $display("FAIL col2_data[%0d]: got %h expected %h", k, r, c_col2_out);
        end
        n_checks++;
        if (!ok_after) begin
            n_fail++; $display("FAIL col2_release[%0d]: got out_valid=%b in_ready=%b expected 0/1",
                               k, out_valid[k], in_ready[k]);
        end
    endtask

    task automatic test_backpressure();
        int n;
        out_ready[0] = 1'b0;
        in_data[0]   = c_fips_in;
        in_valid[0]  = 1'b1;
        @(posedge clk); #1;
        in_valid[0]  = 1'b0;
        n = 0;
        while (out_valid[0] !== 1'b1 && n < 10) begin
            @(posedge clk); #1; n++;
        end
        n_checks++;
        if (out_valid[0] !== 1'b1) begin
            n_fail++; $display("FAIL bp_valid_rise: got %b expected 1", out_valid[0]);
        end
        // A competing input is presented while the result is stalled.
        in_data[0]  = c_col1_in;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid[0], in_ready[0], busy[0]} !== 3'b101) begin
                n_fail++; $display("FAIL bp_flags cycle %0d: got v/r/b=%b%b%b expected 101",
                                   i, out_valid[0], in_ready[0], busy[0]);
            end
            n_checks++;
            if (out_data[0] !== c_fips_out) begin
                n_fail++; $display("FAIL bp_hold_data cycle %0d: got %h expected %h", i, out_data[0], c_fips_out);
            end
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0", in_ready[0], out_valid[0]);
        end
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        n_checks++;
        if (busy[0] !== 1'b1) begin
            n_fail++; $display("FAIL bp_second_accept: got busy=%b expected 1", busy[0]);
        end
        n = 0;
        while (out_valid[0] !== 1'b1 && n < 10) begin
            @(posedge clk); #1; n++;
        end
        n_checks++;
        if (out_valid[0] !== 1'b1 || out_data[0] !== c_col1_out) begin
            n_fail++; $display("FAIL bp_second_data: got v=%b %h expected 1 %h", out_valid[0], out_data[0], c_col1_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int seen;
        logic [127:0] r;
        int lat;
        bit ok_after;
        out_ready[0] = 1'b1;
        in_data[0]   = c_fips_in;
        in_valid[0]  = 1'b1;
        @(posedge clk); #1;
        in_valid[0]  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #4 rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
            n_fail++; $display("FAIL midrst_flags: got v/r/b=%b%b%b expected 010", out_valid[0], in_ready[0], busy[0]);
        end
        n_checks++;
        if (out_data[0] !== 128'd0) begin
            n_fail++; $display("FAIL midrst_data: got %h expected 0", out_data[0]);
        end
        #2 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid[0] === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++; $display("FAIL midrst_no_output: got %0d valid cycles expected 0", seen);
        end
        run_one(0, c_col2_in, r, lat, ok_after);
        n_checks++;
        if (r !== c_col2_out) begin
            n_fail++; $display("FAIL midrst_next_data: got %h expected %h", r, c_col2_out);
        end
    endtask

    task automatic test_back_to_back(input int k);
        int got;
        exp_q.delete();
        got = 0;
        out_ready[k] = ($urandom_range(0, 3) != 0);
        fork
            begin : producer
                logic [127:0] d;
                bit acc;
                int w;
                int gap;
                for (int i = 0; i < c_nrand; i++) begin
                    gap = $urandom_range(0, 2);
                    d = {$urandom, $urandom, $urandom, $urandom};
                    in_data[k]  = d;
                    in_valid[k] = 1'b1;
                    acc = 1'b0;
                    w = 0;
                    while (!acc && w < 50) begin
                        @(negedge clk);
                        if (in_ready[k] === 1'b1) begin
                            acc = 1'b1;
                            exp_q.push_back(ref_mix(d));
                        end
                        @(posedge clk); #1;
                        w++;
                    end
                    in_valid[k] = 1'b0;
                    in_data[k]  = ~d;
                    if (!acc) begin
                        n_checks++; n_fail++;
                        $display("FAIL b2b_accept_timeout[%0d]: item %0d not accepted within %0d cycles", k, i, w);
                        break;
                    end
                    repeat (gap) begin
                        @(posedge clk); #1;
                    end
                end
            end
            begin : consumer
                logic [127:0] e;
                int cyc;
                cyc = 0;
                while (got < c_nrand && cyc < 20000) begin
                    @(negedge clk);
                    if (out_valid[k] === 1'b1 && out_ready[k] === 1'b1) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++; $display("FAIL b2b_extra_output[%0d]: got %h expected none", k, out_data[k]);
                        end else begin
                            e = exp_q.pop_front();
                            if (out_data[k] !== e) begin
                                n_fail++; $display("FAIL b2b_data[%0d] item %0d: got %h expected %h", k, got, out_data[k], e);
                            end
                        end
                        got++;
                    end
                    @(posedge clk); #1;
                    out_ready[k] = ($urandom_range(0, 3) != 0);
                    cyc++;
                end
            end
        join
        out_ready[k] = 1'b1;
        n_checks++;
        if (got != c_nrand || exp_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_count[%0d]: got %0d outputs, %0d pending, expected %0d and 0",
                               k, got, exp_q.size(), c_nrand);
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            out_ready[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        for (int k = 0; k < 3; k++) begin
            test_fips(k);
            test_columns(k);
        end
        test_backpressure();
        test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            test_back_to_back(k);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
